// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared types and constants for the JTAG RAM scan-chain loader.
//   WORD_W              : width of one chain word (32 bits)
//   DEFAULT_CHAIN_WORDS : default number of words in the attached RAM chain
//   state_t             : loader state enumeration
// -----------------------------------------------------------------------------
package jtag_pkg;

    localparam int WORD_W              = 32;
    localparam int DEFAULT_CHAIN_WORDS = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/jtag_chain_loader.sv
// -----------------------------------------------------------------------------
// jtag_chain_loader
// Shifts a host word stream through a RAM scan chain of CHAIN_WORDS 32-bit
// words, one word per Jen cycle, and (optionally) returns the words that fall
// out of the far end of the chain as a second stream.
//
// Optional feature macro: JTAG_LOADER_READBACK_EN
//   defined   : out stream is live, Jen also waits for room in the out register
//   undefined : out_valid/out_data tied to 0, Jout and out_ready ignored,
//               DRAIN lasts a single cycle
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : begin a full-chain shift (only honoured in IDLE)
//   abort                 : end a shift early (only honoured in SHIFT)
//   in_valid/in_ready     : host word stream handshake, in_data is the word
//   out_valid/out_ready   : shifted-out word stream, out_data is the word
//   Jen, Jin, Jout        : chain shift enable, chain input, chain output
//   busy                  : state is not IDLE
//   done                  : one-cycle completion pulse
//   aborted               : sticky, set by abort, cleared by start
//   count                 : words shifted in the current operation
// -----------------------------------------------------------------------------
module jtag_chain_loader
    import jtag_pkg::*;
#(
    parameter int CHAIN_WORDS = DEFAULT_CHAIN_WORDS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_W-1:0]                out_data,
    output logic                             Jen,
    output logic [WORD_W-1:0]                Jin,
    input  logic [WORD_W-1:0]                Jout,
    output logic                             busy,
    output logic                             done,
    output logic                             aborted,
    output logic [$clog2(CHAIN_WORDS+1)-1:0] count
);

    localparam int              CW         = $clog2(CHAIN_WORDS + 1);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(CHAIN_WORDS - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_count;
    logic          r_aborted;
    logic          w_out_free;     // out register can accept a capture this cycle
    logic          w_drain_empty;  // nothing left to hand to the out stream
    logic          w_jen;
    logic          w_abort;
    logic          w_start;

    assign w_start = (r_state == IDLE)  && start;
    assign w_abort = (r_state == SHIFT) && abort;

    // Abort wins over a shift in the same cycle so the chain is never moved
    // on the cycle the host asked to stop.
    assign w_jen = (r_state == SHIFT) && in_valid && w_out_free && !abort;

`ifdef JTAG_LOADER_READBACK_EN
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;

    assign w_out_free    = !r_out_valid || out_ready;
    assign w_drain_empty = !r_out_valid;

    // A capture takes precedence over a drain: when both happen the register
    // simply stays valid and takes the new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_jen) begin
            r_out_valid <= 1'b1;
            r_out_data  <= Jout;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
`else
    logic w_unused_readback;

    assign w_out_free        = 1'b1;
    assign w_drain_empty     = 1'b1;
    assign out_valid         = 1'b0;
    assign out_data          = '0;
    assign w_unused_readback = ^{Jout, out_ready};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_count   <= '0;
                r_aborted <= 1'b0;
            end else begin
                if (w_jen) begin
                    r_count <= r_count + CW'(1);
                end
                if (w_abort) begin
                    r_aborted <= 1'b1;
                end
            end
        end
    end

    // NOTE: the default is assigned before the case so no path leaves
    // w_next_state unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_next_state = DRAIN;
                end else if (w_jen && (r_count == LAST_COUNT)) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drain_empty) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign Jen      = w_jen;
    assign in_ready = w_jen;
    assign Jin      = in_data;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign aborted  = r_aborted;
    assign count    = r_count;

endmodule

// File: tb/tb_jtag_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_jtag_chain_loader
// Bench for jtag_chain_loader against a 512-word RAM scan chain model.
// Expected chain images and out-stream words are computed arithmetically from
// the preloaded contents and the host words: after m shifts, address a holds
// pre[a-m] when a >= m, else host word m-1-a; out word k is pre[N-1-k].
// Honours JTAG_LOADER_READBACK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_jtag_chain_loader;

    localparam int N       = 512;
    localparam int CW      = $clog2(N + 1);
    localparam int MAX_CYC = 6000;
`ifdef JTAG_LOADER_READBACK_EN
    localparam int EXP_LAT = 514;
`else
    localparam int EXP_LAT = 513;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          Jen;
    logic [31:0]   Jin;
    logic [31:0]   Jout;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    jtag_chain_loader #(
        .CHAIN_WORDS (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .Jen       (Jen),
        .Jin       (Jin),
        .Jout      (Jout),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .count     (count)
    );

    // ---------------- RAM scan chain model ----------------
    logic [31:0] ram [N];
    logic [31:0] pre [N];
    logic [31:0] src [N];
    int          pre_gen  = 0;
    int          pre_seen = 0;

    assign Jout = ram[N-1];

    always @(posedge clk) begin
        if (pre_gen != pre_seen) begin
            for (int a = 0; a < N; a++) ram[a] <= pre[a];
            pre_seen <= pre_gen;
        end else if (Jen) begin
            for (int i = N - 1; i > 0; i--) ram[i] <= ram[i-1];
            ram[0] <= Jin;
        end
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    int          cyc           = 0;
    int          jen_total     = 0;
    int          done_total    = 0;
    int          done_cyc      = 0;
    int          viol_total    = 0;
    int          ov_total      = 0;
    int          rdy_bad_total = 0;
    int          jin_bad_total = 0;
    logic [31:0] got_q [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (Jen) jen_total++;
            if (Jen && out_valid && !out_ready) viol_total++;
            if (in_ready !== Jen) rdy_bad_total++;
            if (Jin !== in_data) jin_bad_total++;
            if (out_valid) ov_total++;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) begin
                done_total++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ram_bad(input int m);
        int          bad;
        logic [31:0] e;
        bad = 0;
        for (int a = 0; a < N; a++) begin
            e = (a >= m) ? pre[a-m] : src[m-1-a];
            if (ram[a] !== e) bad++;
        end
        return bad;
    endfunction

    int jen_base, done_base, viol_base, ov_base, got_base;
    int start_cyc, cnt_after_start;

    function automatic int out_bad(input int m);
        int bad;
        bad = 0;
        for (int k = 0; k < m; k++) begin
            if (got_q[got_base + k] !== pre[N-1-k]) bad++;
        end
        return bad;
    endfunction

    // kind 0: RAM[a]=a and host words 0x1000+k; otherwise random contents.
    task automatic preload(input int kind);
        for (int a = 0; a < N; a++) begin
            pre[a] = (kind == 0) ? 32'(a)           : $urandom;
            src[a] = (kind == 0) ? 32'(32'h1000 + a) : $urandom;
        end
        pre_gen++;
    endtask

    // pat 0: steady stream, 1: in_valid every other cycle with a 5-cycle
    // out_ready gap, 2: random valid/ready plus stray start pulses,
    // 3: steady input with out_ready held low.
    task automatic run_load(input int pat, input int abort_at, input int stop_at,
                            output bit finished);
        int k;
        bit abort_sent;
        abort_sent = 1'b0;
        finished   = 1'b0;
        jen_base   = jen_total;
        done_base  = done_total;
        viol_base  = viol_total;
        ov_base    = ov_total;
        got_base   = got_q.size();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start           = 1'b0;
        start_cyc       = cyc;
        cnt_after_start = int'(count);
        for (int c = 0; c < MAX_CYC; c++) begin
            if (done_total != done_base) begin
                finished = 1'b1;
                break;
            end
            if (stop_at >= 0 && int'(count) == stop_at) break;
            k       = jen_total - jen_base;
            in_data = (k < N) ? src[k] : 32'h0;
            start   = 1'b0;
            case (pat)
                0: begin in_valid = 1'b1; out_ready = 1'b1; end
                1: begin
                    in_valid  = (c % 2 == 0);
                    out_ready = !(c >= 200 && c < 205);
                end
                2: begin
                    in_valid  = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                    start     = ($urandom_range(0, 15) == 0);
                end
                default: begin in_valid = 1'b1; out_ready = 1'b0; end
            endcase
            if (abort_at >= 0 && !abort_sent && busy && int'(count) == abort_at) begin
                abort      = 1'b1;
                in_valid   = 1'b1;
                out_ready  = 1'b1;
                abort_sent = 1'b1;
            end else begin
                abort = 1'b0;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
        if (stop_at < 0) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic finish_checks(input string tag, input int m);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".done_once"}, done_total - done_base, 1);
        check({tag, ".busy_idle"}, 32'(busy), 0);
        check({tag, ".count_clr"}, cnt_after_start, 0);
        check({tag, ".count_end"}, 32'(count), m);
        check({tag, ".jen_cycles"}, jen_total - jen_base, m);
        check({tag, ".stall"}, viol_total - viol_base, 0);
        check({tag, ".ram_bad"}, ram_bad(m), 0);
`ifdef JTAG_LOADER_READBACK_EN
        check({tag, ".out_num"}, got_q.size() - got_base, m);
        check({tag, ".out_bad"}, out_bad(m), 0);
        check({tag, ".out_empty"}, 32'(out_valid), 0);
`else
        check({tag, ".ov_never"}, ov_total - ov_base, 0);
        check({tag, ".od_zero"}, out_data, 0);
`endif
    endtask

    // ---------------- main sequence ----------------
    bit fin;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        preload(1);
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy",      32'(busy),      0);
        check("rst.done",      32'(done),      0);
        check("rst.jen",       32'(Jen),       0);
        check("rst.count",     32'(count),     0);
        check("rst.out_valid", 32'(out_valid), 0);
        check("rst.out_data",  out_data,       0);
        check("rst.aborted",   32'(aborted),   0);
        @(negedge clk);
        reset = 1'b0;

        // abort and in_valid while idle: nothing may move
        @(posedge clk); #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        #2;
        check("idle.jen", 32'(Jen), 0);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check("idle.aborted", 32'(aborted), 0);
        check("idle.busy",    32'(busy),    0);

        // full load, RAM[a]=a, words 0x1000+k
        preload(0);
        run_load(0, -1, -1, fin);
        check("full.finished", 32'(fin), 1);
        check("full.latency", done_cyc - start_cyc, EXP_LAT);
        check("full.aborted", 32'(aborted), 0);
        finish_checks("full", N);

        // abort at count=100 with a shift condition present
        preload(1);
        run_load(0, 100, -1, fin);
        check("abort.finished", 32'(fin), 1);
        check("abort.aborted", 32'(aborted), 1);
        finish_checks("abort", 100);

        // gapped input with an out_ready hole; start clears aborted
        preload(1);
        run_load(1, -1, -1, fin);
        check("gap.finished", 32'(fin), 1);
        check("gap.aborted", 32'(aborted), 0);
        finish_checks("gap", N);

        // asynchronous reset between edges at count=37
        preload(1);
        run_load(0, -1, 37, fin);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("arst.jen",       32'(Jen),       0);
        check("arst.busy",      32'(busy),      0);
        check("arst.count",     32'(count),     0);
        check("arst.done",      32'(done),      0);
        check("arst.out_valid", 32'(out_valid), 0);
        check("arst.out_data",  out_data,       0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;

        // restart after reset with random handshakes
        preload(1);
        run_load(2, -1, -1, fin);
        check("restart.finished", 32'(fin), 1);
        finish_checks("restart", N);

        preload(1);
        run_load(2, -1, -1, fin);
        check("rand.finished", 32'(fin), 1);
        finish_checks("rand", N);

`ifndef JTAG_LOADER_READBACK_EN
        // out_ready held low must not stall the load without readback
        preload(1);
        run_load(3, -1, -1, fin);
        check("noready.finished", 32'(fin), 1);
        check("noready.latency", done_cyc - start_cyc, EXP_LAT);
        finish_checks("noready", N);
`endif

        check("glob.ready_eq_jen", rdy_bad_total, 0);
        check("glob.jin_eq_data",  jin_bad_total, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jtag_chain_loader.md
JTAG_CHAIN_LOADER -- requirements
Module: jtag_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_WORDS, default 512, meaning the number of 32-bit words in the attached RAM scan chain (range 2..4096).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit, begins a full-chain shift when idle.
REQ-005 SHALL have port abort, input, 1 bit, ends a shift early.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 32), forming the host word stream to be shifted into the chain.
REQ-007 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 32), forming the stream of words shifted out of the chain.
REQ-008 SHALL have ports Jen (output, 1), Jin (output, 32) and Jout (input, 32), which connect to the RAM chain's shift enable, chain input and chain output.
REQ-009 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-011 SHALL have port aborted, output, 1 bit, a sticky flag that is set by abort and cleared by start.
REQ-012 SHALL have port count, output, clog2(CHAIN_WORDS+1) bits, giving the number of words shifted in the current operation.

Function
REQ-013 SHALL implement the states IDLE, SHIFT, DRAIN and DONE, and SHALL enter IDLE from reset.
REQ-014 SHALL move from IDLE to SHIFT when start=1 and SHALL clear count and aborted on that transition; start SHALL be ignored in any state other than IDLE.
REQ-015 SHALL drive Jen combinationally as (state==SHIFT) && in_valid && (out register empty || out_ready).
REQ-016 SHALL drive in_ready equal to Jen, so that one input word is consumed per Jen cycle.
REQ-017 SHALL drive Jin equal to in_data at all times; Jin is don't-care when Jen=0.
REQ-018 SHALL, on each clock edge where Jen=1, load out_data with Jout, set out_valid, and increment count.
REQ-019 SHALL give out_data a latency of 1 cycle from the Jen cycle.
REQ-020 SHALL clear out_valid when out_valid && out_ready and no new capture occurs in the same cycle.
REQ-021 SHALL, when capture and drain occur in the same cycle, keep out_valid=1 and load the new data.
REQ-022 SHALL move from SHIFT to DRAIN on the Jen edge where count reaches CHAIN_WORDS.
REQ-023 SHALL move from DRAIN to DONE once out_valid=0.
REQ-024 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL, after CHAIN_WORDS shifts, leave the k-th word shifted in (k=0..N-1) at RAM address N-1-k, where N=CHAIN_WORDS.
REQ-026 SHALL emit the k-th out word equal to the prior content of address N-1-k.
REQ-027 SHALL, on abort=1 in SHIFT, go to DRAIN with aborted=1; no Jen SHALL occur in that cycle; the chain is left partially shifted.
REQ-028 SHALL ignore abort in any state other than SHIFT.
REQ-029 SHALL, when abort and Jen conditions coincide, give abort priority.
REQ-030 SHALL keep Jen=0 whenever in_valid=0, without advancing state or count.

Reset
REQ-031 SHALL, on reset assertion, immediately force state=IDLE, Jen=0, out_valid=0, out_data=0, count=0, done=0, busy=0 and aborted=0, regardless of clk.
REQ-032 SHALL, on a reset asserted mid-shift, not complete the shift; the RAM contents are then undefined from the loader's view.

Configuration
REQ-033 SHALL, when macro JTAG_LOADER_READBACK_EN is defined, implement the out stream exactly as above.
REQ-034 SHALL, when JTAG_LOADER_READBACK_EN is undefined, tie out_valid=0 and out_data=0, ignore Jout and out_ready, reduce Jen to (state==SHIFT) && in_valid, and pass through DRAIN in one cycle.

Structure
REQ-035 SHALL place the state enumeration type and the default chain-length constant (512) in the shared package jtag_pkg.
REQ-036 SHALL be a single module with no sub-module; the out register is inline.

Verification
REQ-037 SHALL have a bench scenario where, with readback enabled and against a 512-word chain model, start, 512 words 0x1000+k and out_ready=1 always produce Jen 512 cycles, done at cycle 514, and RAM[511-k]=0x1000+k.
REQ-038 SHALL have a bench scenario where, with the chain preloaded with RAM[a]=a, a full shift yields out word k = 511-k in order with no loss.
REQ-039 SHALL have a bench scenario where in_valid toggles every other cycle and out_ready is low for 5 cycles mid-run; Jen is then never high with a full unready out register, count ends at 512, and data is unchanged.
REQ-040 SHALL have a bench scenario where abort is asserted at count=100 together with a Jen condition; then no shift occurs, aborted=1, done pulses after drain, and count=100.
REQ-041 SHALL have a bench scenario where reset is asserted asynchronously at count=37, between clock edges; then Jen=0, busy=0 and count=0 immediately, and a following start restarts from count 0.
REQ-042 SHALL have a bench scenario where, with the macro undefined, a 512-word load completes with out_valid constantly 0, and out_ready=0 does not stall the load.
